// File: rtl/bsg_resource_occupancy_pkg.sv
// Shared definitions for the resource occupancy tracker: the per-slot state
// encoding and the latency value that means "hold until explicit release".
package bsg_resource_occupancy_pkg;

  typedef enum logic [1:0] {
    e_occ_idle  = 2'd0,
    e_occ_timed = 2'd1,
    e_occ_held  = 2'd2
  } occ_state_e;

  // An issue latency of this value parks the slot in HELD instead of timing out.
  localparam int unsigned occ_held_lat_lp = 0;

endpackage

// File: rtl/bsg_resource_occupancy_slot.sv
// One occupancy slot: IDLE / TIMED / HELD state machine plus countdown.
// avail_o is a flop output so the scheduler never sees a combinational path
// from issue or release back into its availability inputs.
module bsg_resource_occupancy_slot
  import bsg_resource_occupancy_pkg::*;
#(
  parameter int lat_width_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   issue_v_i,
  input  logic [lat_width_p-1:0] lat_i,
  input  logic                   release_i,
  output logic                   avail_o
);

  occ_state_e             r_state;
  logic [lat_width_p-1:0] r_cnt;
  logic                   r_avail;

  // Slot FSM: issue beats release; a timed slot frees itself when cnt reaches 1.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= e_occ_idle;
      r_cnt   <= '0;
      r_avail <= 1'b1;
    end else if (issue_v_i) begin
      r_avail <= 1'b0;
      if (lat_i == lat_width_p'(occ_held_lat_lp)) begin
        r_state <= e_occ_held;
        r_cnt   <= '0;
      end else begin
        r_state <= e_occ_timed;
        r_cnt   <= lat_i;
      end
    end else if (release_i) begin
      r_state <= e_occ_idle;
      r_cnt   <= '0;
      r_avail <= 1'b1;
    end else if (r_state == e_occ_timed) begin
      if (r_cnt == lat_width_p'(1)) begin
        r_state <= e_occ_idle;
        r_cnt   <= '0;
        r_avail <= 1'b1;
      end else begin
        r_cnt <= r_cnt - lat_width_p'(1);
      end
    end
  end

  assign avail_o = r_avail;

`ifndef SYNTHESIS
  // Flag an issue that lands on a slot which is still occupied.
  always @(posedge clk_i) begin
    if (!reset_i && issue_v_i)
      assert (r_state == e_occ_idle) else $error("issue to busy slot");
  end
`endif

endmodule

// File: rtl/bsg_resource_occupancy_tracker.sv
// Resource occupancy tracker: turns scheduler issues into per-resource slot
// availability bitmaps, freed by timeout or explicit release.
// Optional macro BSG_RESOURCE_OCCUPANCY_STATS_EN instantiates per-resource
// busy-cycle counters; without it stat_busy_cycles_o is tied to zero.
module bsg_resource_occupancy_tracker
  import bsg_resource_occupancy_pkg::*;
#(
  parameter  int resources_p    = 2,
  parameter  int max_dep_bits_p = 4,
  parameter  int lat_width_p    = 4,
  parameter  int stat_width_p   = 16,
  localparam int dep_width_lp   = (max_dep_bits_p > 1) ? $clog2(max_dep_bits_p) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   issue_v_i,
  input  logic [resources_p*dep_width_lp-1:0]    issue_res_i,
  input  logic [resources_p*lat_width_p-1:0]     issue_lat_i,
  input  logic [resources_p*max_dep_bits_p-1:0]  release_i,
  output logic [resources_p*max_dep_bits_p-1:0]  avail_o,
  output logic                                   busy_any_o,
  output logic [resources_p*stat_width_p-1:0]    stat_busy_cycles_o,
  input  logic                                   stat_clear_i
);

  logic [resources_p*max_dep_bits_p-1:0] w_avail;
  logic [resources_p-1:0]                w_res_busy;

  for (genvar r = 0; r < resources_p; r++) begin : g_res
    logic [dep_width_lp-1:0] w_idx;
    logic [lat_width_p-1:0]  w_lat;

    assign w_idx = issue_res_i[r*dep_width_lp +: dep_width_lp];
    assign w_lat = issue_lat_i[r*lat_width_p +: lat_width_p];

    for (genvar d = 0; d < max_dep_bits_p; d++) begin : g_slot
      logic w_issue;
      // Only the slot selected by this resource's index sees the issue.
      assign w_issue = issue_v_i & (w_idx == dep_width_lp'(d));

      bsg_resource_occupancy_slot #(
        .lat_width_p (lat_width_p)
      ) u_slot (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .issue_v_i (w_issue),
        .lat_i     (w_lat),
        .release_i (release_i[r*max_dep_bits_p + d]),
        .avail_o   (w_avail[r*max_dep_bits_p + d])
      );
    end

    assign w_res_busy[r] = ~(&w_avail[r*max_dep_bits_p +: max_dep_bits_p]);
  end

  assign avail_o    = w_avail;
  assign busy_any_o = |w_res_busy;

`ifdef BSG_RESOURCE_OCCUPANCY_STATS_EN
  for (genvar r = 0; r < resources_p; r++) begin : g_stat
    logic [stat_width_p-1:0] r_cnt;

    // Count cycles in which this resource has any occupied slot; clear wins, saturate at max.
    always_ff @(posedge clk_i) begin
      if (reset_i || stat_clear_i) begin
        r_cnt <= '0;
      end else if (w_res_busy[r] && !(&r_cnt)) begin
        r_cnt <= r_cnt + stat_width_p'(1);
      end
    end

    assign stat_busy_cycles_o[r*stat_width_p +: stat_width_p] = r_cnt;
  end
`else
  logic w_unused_stat_clear;
  assign w_unused_stat_clear = stat_clear_i;
  assign stat_busy_cycles_o  = '0;
`endif

endmodule

// File: tb/tb_bsg_resource_occupancy_tracker.sv
// Scoreboard bench for bsg_resource_occupancy_tracker. The reference model
// tracks, per slot, the absolute cycle at which it becomes free (or a held
// flag) and per-resource busy-cycle totals. Honours BSG_RESOURCE_OCCUPANCY_STATS_EN.
module tb_bsg_resource_occupancy_tracker;

  localparam int R  = 2;
  localparam int D  = 4;
  localparam int DW = 2;
  localparam int LW = 4;
  localparam int SW = 5;

  logic              clk;
  logic              reset_i;
  logic              issue_v_i;
  logic [R*DW-1:0]   issue_res_i;
  logic [R*LW-1:0]   issue_lat_i;
  logic [R*D-1:0]    release_i;
  logic [R*D-1:0]    avail_o;
  logic              busy_any_o;
  logic [R*SW-1:0]   stat_busy_cycles_o;
  logic              stat_clear_i;

  bsg_resource_occupancy_tracker #(
    .resources_p    (R),
    .max_dep_bits_p (D),
    .lat_width_p    (LW),
    .stat_width_p   (SW)
  ) dut (
    .clk_i              (clk),
    .reset_i            (reset_i),
    .issue_v_i          (issue_v_i),
    .issue_res_i        (issue_res_i),
    .issue_lat_i        (issue_lat_i),
    .release_i          (release_i),
    .avail_o            (avail_o),
    .busy_any_o         (busy_any_o),
    .stat_busy_cycles_o (stat_busy_cycles_o),
    .stat_clear_i       (stat_clear_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [R*D-1:0]  avail;
    logic            busy;
    logic [R*SW-1:0] stat;
    int              cyc;
  } exp_t;

  exp_t sb_q[$];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int free_at [R][D];
  bit held    [R][D];
  int stat_m  [R];
  int cyc;

  // Stimulus for the next cycle
  bit         s_rst, s_iv, s_clr;
  int         s_res [R];
  int         s_lat [R];
  bit [R*D-1:0] s_rel;

  function automatic bit m_avail(int r, int d);
    return !held[r][d] && (cyc >= free_at[r][d]);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp, input int c);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
  endtask

  task automatic tick();
    exp_t e;
    bit [R-1:0] rbusy;
    @(negedge clk);
    rbusy = '0;
    for (int r = 0; r < R; r++) begin
      for (int d = 0; d < D; d++) begin
        e.avail[r*D+d] = m_avail(r, d);
        if (!m_avail(r, d)) rbusy[r] = 1'b1;
      end
`ifdef BSG_RESOURCE_OCCUPANCY_STATS_EN
      e.stat[r*SW +: SW] = SW'(stat_m[r]);
`else
      e.stat[r*SW +: SW] = '0;
`endif
    end
    e.busy = |rbusy;
    e.cyc  = cyc;
    sb_q.push_back(e);

    reset_i      = s_rst;
    issue_v_i    = s_iv;
    stat_clear_i = s_clr;
    release_i    = s_rel;
    for (int r = 0; r < R; r++) begin
      issue_res_i[r*DW +: DW] = DW'(s_res[r]);
      issue_lat_i[r*LW +: LW] = LW'(s_lat[r]);
    end

    if (s_rst) begin
      for (int r = 0; r < R; r++) begin
        stat_m[r] = 0;
        for (int d = 0; d < D; d++) begin
          free_at[r][d] = 0;
          held[r][d]    = 1'b0;
        end
      end
    end else begin
      for (int r = 0; r < R; r++) begin
        if (s_clr) stat_m[r] = 0;
        else if (rbusy[r] && stat_m[r] < (2**SW - 1)) stat_m[r]++;
        for (int d = 0; d < D; d++) begin
          if (s_rel[r*D+d] && !m_avail(r, d)) begin
            held[r][d]    = 1'b0;
            free_at[r][d] = cyc + 1;
          end
        end
      end
      if (s_iv) begin
        for (int r = 0; r < R; r++) begin
          if (s_lat[r] == 0) begin
            held[r][s_res[r]] = 1'b1;
          end else begin
            held[r][s_res[r]]    = 1'b0;
            free_at[r][s_res[r]] = cyc + s_lat[r] + 1;
          end
        end
      end
    end
    cyc++;
    s_rst = 0; s_iv = 0; s_clr = 0; s_rel = '0;
  endtask

  task automatic issue2(input int i0, input int l0, input int i1, input int l1);
    s_iv = 1; s_res[0] = i0; s_lat[0] = l0; s_res[1] = i1; s_lat[1] = l1;
  endtask

  // Monitor: compare every presented cycle against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("avail",    64'(avail_o),            64'(e.avail), e.cyc);
        chk("busy_any", 64'(busy_any_o),         64'(e.busy),  e.cyc);
        chk("stat",     64'(stat_busy_cycles_o), 64'(e.stat),  e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    int idle_list [$];
    bit can_issue;
    int pick [R];

    reset_i = 1'b1; issue_v_i = 1'b0; issue_res_i = '0; issue_lat_i = '0;
    release_i = '0; stat_clear_i = 1'b0;
    s_rst = 0; s_iv = 0; s_clr = 0; s_rel = '0;
    for (int r = 0; r < R; r++) begin
      s_res[r] = 0; s_lat[r] = 0; stat_m[r] = 0;
      for (int d = 0; d < D; d++) begin free_at[r][d] = 0; held[r][d] = 0; end
    end
    cyc = 0;
    repeat (2) @(posedge clk);

    // Reset then idle
    s_rst = 1; tick();
    repeat (10) tick();

    // Timed issues: r0 slot1 lat3, r1 slot2 lat1
    issue2(1, 3, 2, 1); tick();
    repeat (6) tick();

    // Held on r0 slot3, later released
    issue2(3, 0, 0, 2); tick();
    repeat (9) tick();
    s_rel[0*D+3] = 1; tick();
    repeat (3) tick();

    // Same-cycle issue and release on r1 slot0: issue wins
    s_rel[1*D+0] = 1; issue2(0, 1, 0, 2); tick();
    repeat (4) tick();

    // Reset in the middle of a countdown
    issue2(2, 9, 2, 9); tick();
    repeat (2) tick();
    s_rst = 1; tick();
    repeat (3) tick();

    // Statistics accumulation and clear
    issue2(0, 7, 1, 3); tick();
    repeat (12) tick();
    s_clr = 1; tick();
    repeat (3) tick();

    // Held long enough to saturate the counters, then released
    issue2(0, 0, 0, 0); tick();
    repeat (40) tick();
    s_rel[0] = 1; s_rel[D] = 1; tick();
    repeat (3) tick();

    // Randomized traffic, only issuing to slots that are free this cycle
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 29) == 0) s_rst = 1;
      if ($urandom_range(0, 24) == 0) s_clr = 1;
      for (int b = 0; b < R*D; b++)
        if ($urandom_range(0, 7) == 0) s_rel[b] = 1'b1;
      can_issue = ($urandom_range(0, 9) < 4);
      for (int r = 0; r < R; r++) begin
        idle_list.delete();
        for (int d = 0; d < D; d++) if (m_avail(r, d)) idle_list.push_back(d);
        if (idle_list.size() == 0) can_issue = 0;
        else pick[r] = idle_list[$urandom_range(0, idle_list.size() - 1)];
      end
      if (can_issue) begin
        s_iv = 1;
        for (int r = 0; r < R; r++) begin
          s_res[r] = pick[r];
          s_lat[r] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15));
        end
      end
      tick();
    end
    tick();

    repeat (2) @(negedge clk);
    #5;
    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
